// File: rtl/byte_queue.sv
// Byte FIFO between the serial deserializer and its consumer.
// Bytes come in through a level ready/ack handshake and go out on single-cycle pop requests.
module byte_queue #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clock_10KHZ,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         data_in,
    input  logic                     enqueue_in,
    output logic                     ack_out,
    input  logic                     dequeue_in,
    output logic [WIDTH-1:0]         data_out,
    output logic                     data_valid_out,
    output logic [$clog2(DEPTH):0]   len_out,
    output logic                     full_out,
    output logic                     empty_out
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic {IDLE, ACK} state_t;

    state_t            state, state_next;
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [WIDTH-1:0]  mem [DEPTH];
    logic              do_write, do_read;

    assign full_out  = (len_out == LW'(DEPTH));
    assign empty_out = (len_out == '0);
    assign ack_out   = (state == ACK);
    assign do_read   = dequeue_in && !empty_out;

    // One write per handshake: the byte is stored on the IDLE->ACK transition only.
    always_comb begin
        state_next = state;
        do_write   = 1'b0;
        case (state)
            IDLE: begin
                if (enqueue_in && !full_out) begin
                    do_write   = 1'b1;
                    state_next = ACK;
                end
            end
            ACK: begin
                if (!enqueue_in)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock_10KHZ) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_ff @(posedge clock_10KHZ) begin
        if (do_write && !reset)
            mem[wr_ptr] <= data_in;
    end

    always_ff @(posedge clock_10KHZ) begin
        if (reset) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            len_out        <= '0;
            data_out       <= '0;
            data_valid_out <= 1'b0;
        end else begin
            data_valid_out <= do_read;
            if (do_write)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_read) begin
                data_out <= mem[rd_ptr];
                rd_ptr   <= rd_ptr + 1'b1;
            end
            case ({do_write, do_read})
                2'b10:   len_out <= len_out + 1'b1;
                2'b01:   len_out <= len_out - 1'b1;
                default: len_out <= len_out;
            endcase
        end
    end

endmodule

// File: tb/tb_byte_queue.sv
// Directed bench for byte_queue: stimulus pushes expected popped bytes into a queue,
// an independent monitor pops and compares on every data_valid_out pulse.
module tb_byte_queue;

    logic       clock_10KHZ = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] data_in = '0;
    logic       enqueue_in = 1'b0;
    logic       ack_out;
    logic       dequeue_in = 1'b0;
    logic [7:0] data_out;
    logic       data_valid_out;
    logic [3:0] len_out;
    logic       full_out;
    logic       empty_out;

    int unsigned errors = 0;
    int unsigned checks = 0;
    int unsigned pulses = 0;
    logic [7:0]  exp_q[$];

    byte_queue #(.WIDTH(8), .DEPTH(8)) dut (
        .clock_10KHZ    (clock_10KHZ),
        .reset          (reset),
        .data_in        (data_in),
        .enqueue_in     (enqueue_in),
        .ack_out        (ack_out),
        .dequeue_in     (dequeue_in),
        .data_out       (data_out),
        .data_valid_out (data_valid_out),
        .len_out        (len_out),
        .full_out       (full_out),
        .empty_out      (empty_out)
    );

    always #5 clock_10KHZ = ~clock_10KHZ;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock_10KHZ);
    endtask

    // Monitor: every pulse must match the oldest outstanding expected byte.
    always @(negedge clock_10KHZ) begin
        if (data_valid_out) begin
            pulses++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: got data %0h expected no pulse", data_out);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (data_out !== e) begin
                    errors++;
                    $display("FAIL pop_data: got %0h expected %0h", data_out, e);
                end
            end
        end
    end

    task automatic handshake(input logic [7:0] b);
        int unsigned n;
        enqueue_in = 1'b1;
        data_in    = b;
        n = 0;
        tick();
        while (!ack_out && n < 20) begin
            tick();
            n++;
        end
        if (!ack_out)
            check("ack_timeout", 32'(ack_out), 32'd1);
        enqueue_in = 1'b0;
        tick();
        check("ack_drop", 32'(ack_out), 32'd0);
    endtask

    task automatic pop(input logic [7:0] e);
        dequeue_in = 1'b1;
        exp_q.push_back(e);
        tick();
        dequeue_in = 1'b0;
    endtask

    int unsigned p0;

    initial begin
        tick();
        // 1 reset
        reset = 1'b1;
        tick();
        tick();
        check("rst_len", 32'(len_out), 32'd0);
        check("rst_empty", 32'(empty_out), 32'd1);
        check("rst_full", 32'(full_out), 32'd0);
        check("rst_ack", 32'(ack_out), 32'd0);
        check("rst_data", 32'(data_out), 32'd0);
        check("rst_valid", 32'(data_valid_out), 32'd0);
        reset = 1'b0;

        // 2 long handshake writes once
        enqueue_in = 1'b1;
        data_in    = 8'hA5;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hs_ack", 32'(ack_out), 32'd1);
            check("hs_len", 32'(len_out), 32'd1);
        end
        enqueue_in = 1'b0;
        tick();
        check("hs_ack_drop", 32'(ack_out), 32'd0);
        check("hs_len_after", 32'(len_out), 32'd1);
        pop(8'hA5);
        tick();
        check("hs_empty", 32'(empty_out), 32'd1);

        // 3 fill, reject while full, accept after a pop
        for (int i = 1; i <= 8; i++)
            handshake(8'(i));
        check("fill_full", 32'(full_out), 32'd1);
        check("fill_len", 32'(len_out), 32'd8);
        enqueue_in = 1'b1;
        data_in    = 8'h09;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("full_no_ack", 32'(ack_out), 32'd0);
            check("full_len", 32'(len_out), 32'd8);
        end
        pop(8'h01);
        check("pop_len7", 32'(len_out), 32'd7);
        check("pop_not_full", 32'(full_out), 32'd0);
        check("pop_no_ack_yet", 32'(ack_out), 32'd0);
        tick();
        check("retry_ack", 32'(ack_out), 32'd1);
        check("retry_len", 32'(len_out), 32'd8);
        enqueue_in = 1'b0;
        tick();
        check("retry_ack_drop", 32'(ack_out), 32'd0);

        // 4 drain with dequeue_in held, across pointer wrap
        p0 = pulses;
        dequeue_in = 1'b1;
        for (int i = 2; i <= 9; i++)
            exp_q.push_back(8'(i));
        for (int i = 0; i < 8; i++)
            tick();
        dequeue_in = 1'b0;
        tick();
        check("drain_pulses", pulses - p0, 32'd8);
        check("drain_empty", 32'(empty_out), 32'd1);
        check("drain_len", 32'(len_out), 32'd0);
        check("drain_q", exp_q.size(), 32'd0);
        p0 = pulses;
        dequeue_in = 1'b1;
        tick();
        dequeue_in = 1'b0;
        tick();
        check("empty_pop_pulses", pulses - p0, 32'd0);
        check("empty_pop_data", 32'(data_out), 32'h09);
        check("empty_pop_len", 32'(len_out), 32'd0);

        // 5 simultaneous write and pop
        handshake(8'h11);
        handshake(8'h22);
        handshake(8'h33);
        check("sim_len_pre", 32'(len_out), 32'd3);
        enqueue_in = 1'b1;
        data_in    = 8'hC3;
        pop(8'h11);
        check("sim_len", 32'(len_out), 32'd3);
        check("sim_ack", 32'(ack_out), 32'd1);
        enqueue_in = 1'b0;
        tick();
        pop(8'h22);
        pop(8'h33);
        pop(8'hC3);
        tick();
        check("sim_empty", 32'(empty_out), 32'd1);

        // 6 reset in the middle of a handshake
        enqueue_in = 1'b1;
        data_in    = 8'h5A;
        tick();
        check("mid_ack", 32'(ack_out), 32'd1);
        check("mid_len", 32'(len_out), 32'd1);
        reset = 1'b1;
        tick();
        check("mid_rst_ack", 32'(ack_out), 32'd0);
        check("mid_rst_len", 32'(len_out), 32'd0);
        check("mid_rst_empty", 32'(empty_out), 32'd1);
        check("mid_rst_data", 32'(data_out), 32'd0);
        reset = 1'b0;
        enqueue_in = 1'b0;
        tick();
        enqueue_in = 1'b1;
        data_in    = 8'h77;
        tick();
        check("post_rst_ack", 32'(ack_out), 32'd1);
        check("post_rst_len", 32'(len_out), 32'd1);
        enqueue_in = 1'b0;
        tick();
        pop(8'h77);
        tick();
        tick();
        check("final_q", exp_q.size(), 32'd0);
        check("final_data", 32'(data_out), 32'h77);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
